// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the dm_responder data-memory responder.
package dm_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Largest legal WAIT_CYCLES; the wait counter is sized to hold it.
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/dm_resp_array.sv
// Synchronous single-port data array with per-byte write enables.
// Read data is registered on the commit edge and cleared for stores.
module dm_resp_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write; the array contents are never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Capture load data (or zero for a store) when the access commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (en) rdata <= we ? '0 : mem[addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding word access over valid/ready,
// WAIT_CYCLES wait states between accept and response.
// Optional byte-enable port: define DM_RESPONDER_BYTE_WRITE_EN.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef DM_RESPONDER_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy
);

  if (WAIT_CYCLES > WAIT_MAX) begin : g_wait_range
    $error("dm_responder: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                accept, commit;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                c_we;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic [DATA_W/8-1:0] c_be;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access commits on the accept edge, so the
  // array is fed straight from the request inputs while IDLE.
  assign c_we    = (state == IDLE) ? req_we    : lat_we;
  assign c_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : lat_wdata;

`ifdef DM_RESPONDER_BYTE_WRITE_EN
  logic [DATA_W/8-1:0] lat_be;

  // Hold the byte enables of the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lat_be <= '0;
    else if (accept) lat_be <= req_be;
  end

  assign c_be = (state == IDLE) ? req_be : lat_be;
`else
  assign c_be = '1;
`endif

  // State, wait counter, accepted request and echoed write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_we    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) rsp_we <= c_we;
    end
  end

  // Next-state, counter and commit decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dm_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (commit),
    .we    (c_we),
    .be    (c_be),
    .addr  (c_addr),
    .wdata (c_wdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance (a) and a
// WAIT_CYCLES=0 instance (b) sharing clock, reset and request data.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        rsp_ready = 1'b0;
  logic        req_ready_a, rsp_valid_a, rsp_we_a, busy_a;
  logic        req_ready_b, rsp_valid_b, rsp_we_b, busy_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;

  logic        sel = 1'b0;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_we, cur_busy;
  logic [31:0] cur_rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DM_RESPONDER_BYTE_WRITE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_we(rsp_we_a),
    .rsp_rdata(rsp_rdata_a), .busy(busy_a)
  );

  dm_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DM_RESPONDER_BYTE_WRITE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_we(rsp_we_b),
    .rsp_rdata(rsp_rdata_b), .busy(busy_b)
  );

  assign cur_req_ready = sel ? req_ready_b : req_ready_a;
  assign cur_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign cur_rsp_we    = sel ? rsp_we_b    : rsp_we_a;
  assign cur_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  assign cur_busy      = sel ? busy_b      : busy_a;

  typedef struct {
    logic        sel;
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    logic        intrude;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) req_valid_b = v;
    else     req_valid_a = v;
  endtask

  // One complete access on the selected instance, checking handshake,
  // latency, response contents, backpressure stability and return to IDLE.
  task automatic access(input logic s, input logic we, input logic [10:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int stall, input logic intrude,
                        input logic [31:0] exp, input string name);
    int edges;
    int wc;
    wc = s ? 0 : 2;
    sel = s;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr[9:0];
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (stall == 0);
    set_valid(1'b1);
    #1;
    chk({name, " req_ready idle"}, 32'(cur_req_ready), 32'd1);
    @(posedge clk); #1;
    set_valid(1'b0);
    edges = 1;
    chk({name, " busy after accept"}, 32'(cur_busy), 32'd1);
    while (!cur_rsp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({name, " latency"}, 32'(edges), 32'(wc + 1));
    chk({name, " rsp_we"}, 32'(cur_rsp_we), 32'(we));
    chk({name, " rsp_rdata"}, cur_rsp_rdata, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (intrude && i == 1) begin
        req_we    = 1'b1;
        req_addr  = 10'h006;
        req_wdata = 32'hBAD0BAD0;
        set_valid(1'b1);
        #1;
        chk({name, " req_ready while busy"}, 32'(cur_req_ready), 32'd0);
      end
      @(posedge clk); #1;
      set_valid(1'b0);
      chk({name, " stall rsp_valid"}, 32'(cur_rsp_valid), 32'd1);
      chk({name, " stall rsp_rdata"}, cur_rsp_rdata, exp);
      chk({name, " stall rsp_we"}, 32'(cur_rsp_we), 32'(we));
    end
    if (stall != 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({name, " rsp_valid drop"}, 32'(cur_rsp_valid), 32'd0);
    chk({name, " back idle"}, 32'(cur_req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    //        sel   we    addr     wdata         be    st int exp
    vecs[0] = '{1'b0, 1'b1, 11'h005, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 11'h005, 32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 11'h006, 32'h600D600D, 4'hF, 0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 11'h005, 32'h0,        4'hF, 5, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 11'h006, 32'h0,        4'hF, 0, 1'b0, 32'h600D600D};
    vecs[5] = '{1'b1, 1'b1, 11'h3FF, 32'h00000001, 4'hF, 0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 11'h3FF, 32'h0,        4'hF, 0, 1'b0, 32'h00000001};
    vecs[7] = '{1'b1, 1'b1, 11'h400, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 11'h000, 32'h0,        4'hF, 2, 1'b0, 32'hA5A5A5A5};
    vecs[9] = '{1'b1, 1'b0, 11'h3FF, 32'h0,        4'hF, 0, 1'b0, 32'h00000001};

    #12;
    chk("reset req_ready a", 32'(req_ready_a), 32'd1);
    chk("reset rsp_valid a", 32'(rsp_valid_a), 32'd0);
    chk("reset busy a", 32'(busy_a), 32'd0);
    chk("reset rsp_we a", 32'(rsp_we_a), 32'd0);
    chk("reset rsp_rdata a", rsp_rdata_a, 32'd0);
    chk("reset rsp_valid b", 32'(rsp_valid_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].stall, vecs[i].intrude, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset while a store is still waiting: dropped, array untouched.
    access(1'b0, 1'b1, 11'h010, 32'h11111111, 4'hF, 0, 1'b0, 32'h0, "rst pre");
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 10'h010; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    chk("rst mid busy before", 32'(busy_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst mid rsp_valid", 32'(rsp_valid_a), 32'd0);
    chk("rst mid busy", 32'(busy_a), 32'd0);
    chk("rst mid req_ready", 32'(req_ready_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 1'b0, 11'h010, 32'h0, 4'hF, 0, 1'b0, 32'h11111111, "rst post load");

`ifdef DM_RESPONDER_BYTE_WRITE_EN
    access(1'b0, 1'b1, 11'h020, 32'h11111111, 4'hF, 0, 1'b0, 32'h0, "be full");
    access(1'b0, 1'b1, 11'h020, 32'hAABBCCDD, 4'b0010, 0, 1'b0, 32'h0, "be byte1");
    access(1'b0, 1'b0, 11'h020, 32'h0, 4'hF, 0, 1'b0, 32'h1111CC11, "be load1");
    access(1'b0, 1'b1, 11'h020, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, 32'h0, "be none");
    access(1'b0, 1'b0, 11'h020, 32'h0, 4'hF, 0, 1'b0, 32'h1111CC11, "be load2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
